// File: rtl/pu_div_ctrl_if.sv
// Bus bundle between pu_div_ctrl and its environment: client operand/result
// streams plus the divider PU strobe/data bus. master = controller side.
interface pu_div_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_numer;
  logic [DATA_WIDTH-1:0] in_denom;
  logic [ATTR_WIDTH-1:0] in_numer_attr;
  logic [ATTR_WIDTH-1:0] in_denom_attr;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_quot;
  logic [DATA_WIDTH-1:0] out_rem;
  logic                  out_invalid;

  logic                  signal_wr;
  logic                  signal_wr_sel;
  logic [DATA_WIDTH-1:0] data_to_pu;
  logic [ATTR_WIDTH-1:0] attr_to_pu;
  logic                  signal_oe;
  logic                  signal_oe_sel;
  logic [DATA_WIDTH-1:0] data_from_pu;
  logic [ATTR_WIDTH-1:0] attr_from_pu;

  modport master (
    input  in_valid, in_numer, in_denom, in_numer_attr, in_denom_attr,
    input  out_ready, data_from_pu, attr_from_pu,
    output in_ready, out_valid, out_quot, out_rem, out_invalid,
    output signal_wr, signal_wr_sel, data_to_pu, attr_to_pu,
    output signal_oe, signal_oe_sel
  );

  modport slave (
    output in_valid, in_numer, in_denom, in_numer_attr, in_denom_attr,
    output out_ready, data_from_pu, attr_from_pu,
    input  in_ready, out_valid, out_quot, out_rem, out_invalid,
    input  signal_wr, signal_wr_sel, data_to_pu, attr_to_pu,
    input  signal_oe, signal_oe_sel
  );
endinterface

// File: rtl/pu_div_ctrl.sv
// Initiator-side controller for the divider PU: write operands, wait out the
// PU latency, read quotient/remainder. Option macro: PU_DIV_CTRL_QUOT_ONLY_EN.
module pu_div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = 0,
  parameter int LATENCY    = 9
) (
  input logic         clk,
  input logic         rst,
  pu_div_ctrl_if.master bus
);

`ifdef PU_DIV_CTRL_QUOT_ONLY_EN
  typedef enum logic [3:0] {
    IDLE, WR_NUM, WR_DEN, WAIT, RD_Q0, RD_Q1, DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, WR_NUM, WR_DEN, WAIT, RD_Q0, RD_Q1, RD_R0, RD_R1, DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] numer_q, numer_d;
  logic [DATA_WIDTH-1:0] denom_q, denom_d;
  logic [ATTR_WIDTH-1:0] nattr_q, nattr_d;
  logic [ATTR_WIDTH-1:0] dattr_q, dattr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic                  inv_q, inv_d;
`ifndef PU_DIV_CTRL_QUOT_ONLY_EN
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
`endif

  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wr_q, wr_d;
  logic                  wr_sel_q, wr_sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ATTR_WIDTH-1:0] attr_q, attr_d;
  logic                  oe_q, oe_d;
  logic                  oe_sel_q, oe_sel_d;
  logic                  rd_state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      numer_q     <= '0;
      denom_q     <= '0;
      nattr_q     <= '0;
      dattr_q     <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      inv_q       <= 1'b0;
`ifndef PU_DIV_CTRL_QUOT_ONLY_EN
      rem_q       <= '0;
`endif
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      wr_sel_q    <= 1'b0;
      data_q      <= '0;
      attr_q      <= '0;
      oe_q        <= 1'b0;
      oe_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      numer_q     <= numer_d;
      denom_q     <= denom_d;
      nattr_q     <= nattr_d;
      dattr_q     <= dattr_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      inv_q       <= inv_d;
`ifndef PU_DIV_CTRL_QUOT_ONLY_EN
      rem_q       <= rem_d;
`endif
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wr_q        <= wr_d;
      wr_sel_q    <= wr_sel_d;
      data_q      <= data_d;
      attr_q      <= attr_d;
      oe_q        <= oe_d;
      oe_sel_q    <= oe_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    numer_d = numer_q;
    denom_d = denom_q;
    nattr_d = nattr_q;
    dattr_d = dattr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    inv_d   = inv_q;
`ifndef PU_DIV_CTRL_QUOT_ONLY_EN
    rem_d   = rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          numer_d = bus.in_numer;
          denom_d = bus.in_denom;
          nattr_d = bus.in_numer_attr;
          dattr_d = bus.in_denom_attr;
          inv_d   = 1'b0;
          state_d = WR_NUM;
        end
      end
      WR_NUM: state_d = WR_DEN;
      WR_DEN: begin
        cnt_d   = 8'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
        else             state_d = RD_Q0;
      end
      RD_Q0: state_d = RD_Q1;
      RD_Q1: begin
        quot_d  = bus.data_from_pu;
        inv_d   = inv_q | bus.attr_from_pu[INVALID];
`ifdef PU_DIV_CTRL_QUOT_ONLY_EN
        state_d = DONE;
`else
        state_d = RD_R0;
`endif
      end
`ifndef PU_DIV_CTRL_QUOT_ONLY_EN
      RD_R0: state_d = RD_R1;
      RD_R1: begin
        rem_d   = bus.data_from_pu;
        inv_d   = inv_q | bus.attr_from_pu[INVALID];
        state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so every port
    // is a flop output and strobes line up with the state they belong to.
`ifdef PU_DIV_CTRL_QUOT_ONLY_EN
    rd_state_d = (state_d == RD_Q0) || (state_d == RD_Q1);
`else
    rd_state_d = (state_d == RD_Q0) || (state_d == RD_Q1) ||
                 (state_d == RD_R0) || (state_d == RD_R1);
`endif
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    wr_d        = (state_d == WR_NUM) || (state_d == WR_DEN);
    wr_sel_d    = (state_d == WR_DEN);
    oe_d        = rd_state_d;
    oe_sel_d    = (state_d == RD_Q0) || (state_d == RD_Q1);
    data_d      = '0;
    attr_d      = '0;
    if (state_d == WR_NUM) begin
      data_d = numer_d;
      attr_d = nattr_d;
    end else if (state_d == WR_DEN) begin
      data_d = denom_d;
      attr_d = dattr_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_quot      = quot_q;
  assign bus.out_invalid   = inv_q;
  assign bus.signal_wr     = wr_q;
  assign bus.signal_wr_sel = wr_sel_q;
  assign bus.data_to_pu    = data_q;
  assign bus.attr_to_pu    = attr_q;
  assign bus.signal_oe     = oe_q;
  assign bus.signal_oe_sel = oe_sel_q;
`ifdef PU_DIV_CTRL_QUOT_ONLY_EN
  assign bus.out_rem       = '0;
`else
  assign bus.out_rem       = rem_q;
`endif

endmodule
